// File: rtl/cam_capture_ctrl.sv
// Frame-level sequencer for the OV7670 capture write path (pclk domain).
// Aligns to a full frame, gates href into the packer and checks line/frame geometry.
module cam_capture_ctrl #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int PW      = 8,
  parameter int LW      = 7,
  parameter int FW      = 8
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic          continuous,
  input  logic          abort,
  input  logic          vsync,
  input  logic          href,
  input  logic          px_wr,
  output logic          cap_en,
  output logic          addr_clr,
  output logic          buf_sel,
  output logic          busy,
  output logic          frame_done,
  output logic          frame_err,
  output logic [LW-1:0] line_cnt,
  output logic [PW-1:0] pix_cnt,
  output logic [FW-1:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, ARM, SYNC, CAPTURE, DONE} state_t;

  localparam logic [PW-1:0] H_PIX_C   = PW'(H_PIX);
  localparam logic [LW-1:0] V_LINES_C = LW'(V_LINES);

  state_t        state, state_nx;
  logic          vs_d, hr_d;
  logic          vs_rise, vs_fall, hr_fall;
  logic [PW-1:0] pix_line;
  logic          cap_en_nx, addr_clr_nx, buf_sel_nx, busy_nx, frame_done_nx, frame_err_nx;
  logic [LW-1:0] line_cnt_nx;
  logic [PW-1:0] pix_cnt_nx;
  logic [FW-1:0] frame_cnt_nx;

  assign vs_rise = vsync & ~vs_d;
  assign vs_fall = ~vsync & vs_d;
  assign hr_fall = ~href & hr_d;

  // Pixel count of the current line including a px_wr that lands on the hr_fall cycle;
  // saturates so a runaway line cannot alias back onto H_PIX.
  assign pix_line = (px_wr && pix_cnt != '1) ? pix_cnt + PW'(1) : pix_cnt;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nx      = state;
    cap_en_nx     = cap_en;
    addr_clr_nx   = 1'b0;
    buf_sel_nx    = buf_sel;
    frame_done_nx = 1'b0;
    frame_err_nx  = frame_err;
    line_cnt_nx   = line_cnt;
    pix_cnt_nx    = pix_cnt;
    frame_cnt_nx  = frame_cnt;

    if (abort) begin
      state_nx  = IDLE;
      cap_en_nx = 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state_nx     = ARM;
          frame_err_nx = 1'b0;
          line_cnt_nx  = '0;
          pix_cnt_nx   = '0;
        end
        ARM: if (vs_rise) state_nx = SYNC;
        SYNC: if (vs_fall) begin
          state_nx     = CAPTURE;
          cap_en_nx    = 1'b1;
          addr_clr_nx  = 1'b1;
          frame_err_nx = 1'b0;
          line_cnt_nx  = '0;
          pix_cnt_nx   = '0;
        end
        CAPTURE: begin
          pix_cnt_nx = pix_line;
          if (hr_fall) begin
            line_cnt_nx = line_cnt + LW'(1);
            pix_cnt_nx  = '0;
            if (pix_line != H_PIX_C) frame_err_nx = 1'b1;
          end
          if (hr_fall && line_cnt_nx == V_LINES_C) begin
            state_nx  = DONE;
            cap_en_nx = 1'b0;
          end else if (vs_rise) begin
            state_nx     = DONE;
            cap_en_nx    = 1'b0;
            frame_err_nx = 1'b1;
          end
        end
        DONE: begin
          frame_done_nx = 1'b1;
          if (!frame_err) begin
            frame_cnt_nx = frame_cnt + FW'(1);
            buf_sel_nx   = ~buf_sel;
          end
          state_nx = continuous ? ARM : IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vs_d       <= 1'b1;
      hr_d       <= 1'b0;
      cap_en     <= 1'b0;
      addr_clr   <= 1'b0;
      buf_sel    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      line_cnt   <= '0;
      pix_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nx;
      vs_d       <= vsync;
      hr_d       <= href;
      cap_en     <= cap_en_nx;
      addr_clr   <= addr_clr_nx;
      buf_sel    <= buf_sel_nx;
      busy       <= busy_nx;
      frame_done <= frame_done_nx;
      frame_err  <= frame_err_nx;
      line_cnt   <= line_cnt_nx;
      pix_cnt    <= pix_cnt_nx;
      frame_cnt  <= frame_cnt_nx;
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: randomized camera timing and packer strobes
// against a frame-level model (per-line pixel tallies, good-frame count).
module tb_cam_capture_ctrl;

  localparam int H  = 12;
  localparam int V  = 8;
  localparam int PW = 4;
  localparam int LW = 4;
  localparam int FW = 2;

  logic          pclk = 1'b0;
  logic          rst, start, continuous, abort, vsync, href, px_wr;
  logic          cap_en, addr_clr, buf_sel, busy, frame_done, frame_err;
  logic [LW-1:0] line_cnt;
  logic [PW-1:0] pix_cnt;
  logic [FW-1:0] frame_cnt;

  cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .PW(PW), .LW(LW), .FW(FW)) dut (
    .pclk(pclk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .vsync(vsync), .href(href), .px_wr(px_wr), .cap_en(cap_en), .addr_clr(addr_clr),
    .buf_sel(buf_sel), .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .line_cnt(line_cnt), .pix_cnt(pix_cnt), .frame_cnt(frame_cnt)
  );

  always #5 pclk = ~pclk;

  int vectors = 0, miscompares = 0;
  int cyc_n = 0;
  int clr_count = 0, done_count = 0, last_done_edge = -1;
  int good_frames = 0;
  int line_px [32];

  always @(negedge pclk) begin
    if (!rst) begin
      if (addr_clr) clr_count++;
      if (frame_done) begin
        done_count++;
        last_done_edge = cyc_n;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic vs, input logic hr, input logic pw);
    vsync = vs;
    href  = hr;
    px_wr = pw;
    @(posedge pclk);
    cyc_n++;
    #1;
  endtask

  function automatic bit frame_bad(input int nlines);
    bit b = (nlines != V);
    for (int l = 0; l < nlines; l++) if (line_px[l] != H) b = 1'b1;
    return b;
  endfunction

  task automatic fill_lines(input int val);
    for (int l = 0; l < 32; l++) line_px[l] = val;
  endtask

  task automatic start_pulse(input string tag);
    check({tag, "_idle"}, busy, 0);
    start = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
  endtask

  // One camera frame: vsync pulse, back porch, nlines lines of href with line_px[l]
  // px_wr strobes (optionally lagging href by one cycle), front porch.
  task automatic send_frame(input string tag, input int nlines, input int abort_line,
                            input int abort_after, output int fall_e, output int end_e);
    int n, len, sent, clr0;
    bit d, pend, p, bad;
    bad = 1'b0;
    end_e = -1;
    clr0 = clr_count;
    repeat (2 + $urandom_range(0, 2)) cyc(1'b1, 1'b0, 1'b0);
    check({tag, "_pre_fall_cap"}, cap_en, 0);
    cyc(1'b0, 1'b0, 1'b0);
    fall_e = cyc_n;
    check({tag, "_cap_en"}, cap_en, 1);
    check({tag, "_addr_clr"}, addr_clr, 1);
    repeat (1 + $urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
    check({tag, "_clr_once"}, clr_count, clr0 + 1);
    for (int l = 0; l < nlines; l++) begin
      n = line_px[l];
      len = n + int'($urandom_range(0, 3));
      d = (l == abort_line) ? 1'b0 : 1'($urandom_range(0, 1));
      pend = 1'b0;
      sent = 0;
      for (int i = 0; i < len; i++) begin
        if (l == abort_line && sent == abort_after) begin
          abort = 1'b1;
          cyc(1'b0, 1'b1, 1'b0);
          abort = 1'b0;
          return;
        end
        p = 1'b0;
        if (sent < n) p = ((n - sent) >= (len - i)) || ($urandom_range(0, 1) == 1);
        if (p) sent++;
        cyc(1'b0, 1'b1, d ? pend : p);
        pend = p;
      end
      check({tag, "_pix_mid"}, pix_cnt, sent - int'(d & pend));
      cyc(1'b0, 1'b0, d & pend);
      end_e = cyc_n;
      bad = bad | (n != H);
      check({tag, "_line_cnt"}, line_cnt, l + 1);
      check({tag, "_pix_clr"}, pix_cnt, 0);
      check({tag, "_line_err"}, frame_err, bad);
      repeat (1 + $urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
    end
    repeat (3 + $urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame_checks(input string tag, input bit err, input int lines,
                              input int done0, input int ev_edge);
    check({tag, "_done_cnt"}, done_count, done0 + 1);
    check({tag, "_done_lat"}, last_done_edge, ev_edge + 1);
    if (!err) good_frames++;
    check({tag, "_err"}, frame_err, err);
    check({tag, "_lines"}, line_cnt, lines);
    check({tag, "_fcnt"}, frame_cnt, good_frames % (1 << FW));
    check({tag, "_bsel"}, buf_sel, good_frames % 2);
  endtask

  initial begin
    int fe, ee, d0, c0, re;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    vsync = 1'b0; href = 1'b0; px_wr = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_ctrl", {cap_en, addr_clr, buf_sel, busy, frame_done, frame_err}, 0);
    check("rst_cnt", {line_cnt, pix_cnt, frame_cnt}, 0);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // nominal single frame
    fill_lines(H);
    start_pulse("nom");
    d0 = done_count;
    send_frame("nom", V, -1, 0, fe, ee);
    frame_checks("nom", frame_bad(V), V, d0, ee);
    check("nom_end_idle", busy, 0);

    // start mid-frame: lines already running, vsync low
    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < H; i++) begin
        if (l == 0 && i == 4) start = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        if (l == 0 && i == 4) begin
          start = 1'b0;
          check("mid_busy", busy, 1);
        end
      end
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      check("mid_cap_off", cap_en, 0);
      check("mid_no_line", line_cnt, 0);
      check("mid_no_pix", pix_cnt, 0);
    end
    d0 = done_count;
    send_frame("mid", V, -1, 0, fe, ee);
    frame_checks("mid", frame_bad(V), V, d0, ee);

    // short line 5
    fill_lines(H);
    line_px[5] = H - 1;
    start_pulse("bad");
    d0 = done_count;
    send_frame("bad", V, -1, 0, fe, ee);
    frame_checks("bad", frame_bad(V), V, d0, ee);

    // over-long line 1
    fill_lines(H);
    line_px[1] = H + 1;
    start_pulse("long");
    d0 = done_count;
    send_frame("long", V, -1, 0, fe, ee);
    frame_checks("long", frame_bad(V), V, d0, ee);

    // short frame: vsync rises after V/2 lines
    fill_lines(H);
    start_pulse("short");
    d0 = done_count;
    send_frame("short", V / 2, -1, 0, fe, ee);
    check("short_no_done", done_count, d0);
    cyc(1'b1, 1'b0, 1'b0);
    re = cyc_n;
    repeat (2) cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    frame_checks("short", frame_bad(V / 2), V / 2, d0, re);
    check("short_idle", busy, 0);

    // continuous, three frames
    fill_lines(H);
    continuous = 1'b1;
    c0 = clr_count;
    start_pulse("cont");
    for (int f = 0; f < 3; f++) begin
      if (f == 2) continuous = 1'b0;
      d0 = done_count;
      send_frame("cont", V, -1, 0, fe, ee);
      frame_checks("cont", frame_bad(V), V, d0, ee);
      check("cont_busy", busy, f < 2);
    end
    check("cont_clr_total", clr_count, c0 + 3);

    // asynchronous reset in the middle of a frame
    start_pulse("rstmid");
    send_frame("rstmid", 3, -1, 0, fe, ee);
    check("rstmid_busy", busy, 1);
    check("rstmid_bsel_pre", buf_sel, good_frames % 2);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_ctrl", {cap_en, addr_clr, buf_sel, busy, frame_done, frame_err}, 0);
    check("rstmid_cnt", {line_cnt, pix_cnt, frame_cnt}, 0);
    good_frames = 0;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);

    // abort in line 2 after 5 pixels, then a clean capture
    fill_lines(H);
    start_pulse("abt");
    d0 = done_count;
    send_frame("abt", V, 2, 5, fe, ee);
    check("abt_cap_en", cap_en, 0);
    check("abt_busy", busy, 0);
    check("abt_lines", line_cnt, 2);
    check("abt_pix", pix_cnt, 5);
    check("abt_fcnt", frame_cnt, good_frames % (1 << FW));
    check("abt_bsel", buf_sel, good_frames % 2);
    for (int l = 0; l < V; l++) begin
      repeat (H) cyc(1'b0, 1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
    end
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("abt_no_done", done_count, d0);
    check("abt_still_idle", busy, 0);
    start_pulse("abt2");
    send_frame("abt2", V, -1, 0, fe, ee);
    frame_checks("abt2", frame_bad(V), V, d0, ee);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
